pipe_hazard_ctrl: RTL and testbench

- Stall/flush controller for the five-stage MIPS pipeline.
- Drives the pause and flush controls of the PC, IF/ID, ID/EX and EX/MEM pipeline registers.
- Resolves load-use hazards, taken branches and jumps, multi-cycle memory waits and syscall halts, and keeps performance counters.
- Sits beside the hazard-free datapath. It takes stage-decoded fields from ID and EX.

---
 rtl/pipe_hazard_ctrl.sv | 177 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline. It detects load-use
// hazards, taken branches and jumps, data-memory waits and halting syscalls,
// drives the pause/flush controls of PC, IF/ID, ID/EX and EX/MEM, and keeps
// saturating performance counters.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RUN      | normal issue; the priority chain resolves new events
// LU_STALL | inserting the remaining load-use bubbles (lu_cnt_q left)
// MEM_WAIT | data memory busy; the whole front of the pipe is held
// HALT     | syscall halt; everything paused until resume
module pipe_hazard_ctrl #(
    parameter int LU_STALL_CYCLES = 1,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs_id,
    input  logic [4:0]       rt_id,
    input  logic             rs_used_id,
    input  logic             rt_used_id,
    input  logic [4:0]       ex_rw,
    input  logic             ex_memtoreg,
    input  logic             ex_regwrite,
    input  logic             branch_taken_ex,
    input  logic             syscall_halt_ex,
    input  logic             mem_busy,
    input  logic             resume,
    input  logic             clr_stats,
    output logic             pc_pause,
    output logic             ifid_pause,
    output logic             ifid_flush,
    output logic             idex_pause,
    output logic             idex_flush,
    output logic             exmem_pause,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [31:0]      cycle_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2,
        HALT     = 2'd3
    } state_t;

    // Bubbles still owed after the first one, which is issued from RUN.
    localparam logic [1:0] LU_RELOAD = 2'(LU_STALL_CYCLES - 1);

    state_t           state_q, state_d;
    logic [1:0]       lu_cnt_q, lu_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic [31:0]      cycle_cnt_q;

    logic load_use;
    logic pc_p, ifid_p, ifid_f, idex_p, idex_f, exmem_p, halt_c;
    logic flush_evt, stall_inc, cycle_inc;

    // Hazard when a load in EX writes a register the ID instruction reads.
    assign load_use = ex_memtoreg & ex_regwrite & (ex_rw != 5'd0) &
                      ((rs_used_id & (rs_id == ex_rw)) |
                       (rt_used_id & (rt_id == ex_rw)));

    // Control outputs and next state from the current state and inputs.
    always_comb begin
        pc_p      = 1'b0;
        ifid_p    = 1'b0;
        ifid_f    = 1'b0;
        idex_p    = 1'b0;
        idex_f    = 1'b0;
        exmem_p   = 1'b0;
        halt_c    = 1'b0;
        flush_evt = 1'b0;
        state_d   = state_q;
        lu_cnt_d  = lu_cnt_q;
        unique case (state_q)
            HALT: begin
                {pc_p, ifid_p, idex_p, exmem_p} = 4'hF;
                halt_c = 1'b1;
                if (resume) state_d = RUN;
            end
            LU_STALL: begin
                if (mem_busy) begin
                    // Memory wait outranks the bubble; the bubble count holds.
                    {pc_p, ifid_p, idex_p, exmem_p} = 4'hF;
                end else begin
                    pc_p     = 1'b1;
                    ifid_p   = 1'b1;
                    idex_f   = 1'b1;
                    lu_cnt_d = lu_cnt_q - 2'd1;
                    if (lu_cnt_q <= 2'd1) begin
                        state_d  = RUN;
                        lu_cnt_d = 2'd0;
                    end
                end
            end
            RUN, MEM_WAIT: begin
                if (state_q == MEM_WAIT && mem_busy) begin
                    {pc_p, ifid_p, idex_p, exmem_p} = 4'hF;
                end else begin
                    state_d = RUN;
                    if (syscall_halt_ex) begin
                        {pc_p, ifid_p, idex_p, exmem_p} = 4'hF;
                        state_d = HALT;
                    end else if (branch_taken_ex) begin
                        // Branch wins over load-use: the dependent instruction is flushed.
                        ifid_f    = 1'b1;
                        idex_f    = 1'b1;
                        flush_evt = 1'b1;
                    end else if (mem_busy) begin
                        {pc_p, ifid_p, idex_p, exmem_p} = 4'hF;
                        state_d = MEM_WAIT;
                    end else if (load_use) begin
                        pc_p   = 1'b1;
                        ifid_p = 1'b1;
                        idex_f = 1'b1;
                        if (LU_STALL_CYCLES > 1) begin
                            state_d  = LU_STALL;
                            lu_cnt_d = LU_RELOAD;
                        end
                    end
                end
            end
            default: begin
                state_d  = RUN;
                lu_cnt_d = 2'd0;
            end
        endcase
    end

    assign stall_inc = pc_p & (state_q != HALT);
    assign cycle_inc = (state_q != HALT);

    // State and bubble-count registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= RUN;
            lu_cnt_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            lu_cnt_q <= lu_cnt_d;
        end
    end

    // Saturating performance counters; clear overrides any increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            cycle_cnt_q <= '0;
        end else if (clr_stats) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            cycle_cnt_q <= '0;
        end else begin
            if (stall_inc && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flush_evt && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            if (cycle_inc && cycle_cnt_q != '1) cycle_cnt_q <= cycle_cnt_q + 32'd1;
        end
    end

    // Controls are forced low for as long as reset is held.
    assign pc_pause    = rst & pc_p;
    assign ifid_pause  = rst & ifid_p;
    assign ifid_flush  = rst & ifid_f;
    assign idex_pause  = rst & idex_p;
    assign idex_flush  = rst & idex_f;
    assign exmem_pause = rst & exmem_p;
    assign halted      = rst & halt_c;

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (1-bubble/16-bit counters and
// 3-bubble/6-bit counters) share one stimulus and are compared every cycle
// against a behavioural model, plus directed scenarios with literal values.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] rs_id = '0, rt_id = '0, ex_rw = '0;
    logic       rs_used_id = 0, rt_used_id = 0, ex_memtoreg = 0, ex_regwrite = 0;
    logic       branch_taken_ex = 0, syscall_halt_ex = 0, mem_busy = 0, resume = 0, clr_stats = 0;

    logic pc1, ip1, if1, dp1, df1, ep1, h1;
    logic pc3, ip3, if3, dp3, df3, ep3, h3;
    logic [15:0] stall1, flush1;
    logic [5:0]  stall3, flush3;
    logic [31:0] cyc1, cyc3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.LU_STALL_CYCLES(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .rs_id(rs_id), .rt_id(rt_id), .rs_used_id(rs_used_id),
        .rt_used_id(rt_used_id), .ex_rw(ex_rw), .ex_memtoreg(ex_memtoreg),
        .ex_regwrite(ex_regwrite), .branch_taken_ex(branch_taken_ex),
        .syscall_halt_ex(syscall_halt_ex), .mem_busy(mem_busy), .resume(resume),
        .clr_stats(clr_stats), .pc_pause(pc1), .ifid_pause(ip1), .ifid_flush(if1),
        .idex_pause(dp1), .idex_flush(df1), .exmem_pause(ep1), .halted(h1),
        .stall_cnt(stall1), .flush_cnt(flush1), .cycle_cnt(cyc1));

    pipe_hazard_ctrl #(.LU_STALL_CYCLES(3), .CNT_W(6)) dut3 (
        .clk(clk), .rst(rst), .rs_id(rs_id), .rt_id(rt_id), .rs_used_id(rs_used_id),
        .rt_used_id(rt_used_id), .ex_rw(ex_rw), .ex_memtoreg(ex_memtoreg),
        .ex_regwrite(ex_regwrite), .branch_taken_ex(branch_taken_ex),
        .syscall_halt_ex(syscall_halt_ex), .mem_busy(mem_busy), .resume(resume),
        .clr_stats(clr_stats), .pc_pause(pc3), .ifid_pause(ip3), .ifid_flush(if3),
        .idex_pause(dp3), .idex_flush(df3), .exmem_pause(ep3), .halted(h3),
        .stall_cnt(stall3), .flush_cnt(flush3), .cycle_cnt(cyc3));

    // Output vector: {pc_pause, ifid_pause, ifid_flush, idex_pause, idex_flush, exmem_pause, halted}
    wire [6:0] o1 = {pc1, ip1, if1, dp1, df1, ep1, h1};
    wire [6:0] o3 = {pc3, ip3, if3, dp3, df3, ep3, h3};

    localparam logic [6:0] NONE  = 7'b0000000;
    localparam logic [6:0] HOLD  = 7'b1101010;
    localparam logic [6:0] BUBL  = 7'b1100100;
    localparam logic [6:0] FLSH  = 7'b0010100;
    localparam logic [6:0] HLTED = 7'b1101011;

    // Behavioural model: k=0 is the 1-bubble instance, k=1 the 3-bubble one.
    bit          halted_m[2];
    bit          waiting_m[2];
    int          pend_m[2];
    longint      stall_m[2], flush_m[2], cyc_m[2];

    function automatic int lu_of(int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic longint max_of(int k);
        return (k == 0) ? 64'd65535 : 64'd63;
    endfunction

    function automatic bit hazard();
        return ex_memtoreg && ex_regwrite && (ex_rw != 0) &&
               ((rs_used_id && rs_id == ex_rw) || (rt_used_id && rt_id == ex_rw));
    endfunction

    function automatic logic [6:0] predict(int k);
        if (halted_m[k])                return HLTED;
        if (pend_m[k] > 0)              return mem_busy ? HOLD : BUBL;
        if (waiting_m[k] && mem_busy)   return HOLD;
        if (syscall_halt_ex)            return HOLD;
        if (branch_taken_ex)            return FLSH;
        if (mem_busy)                   return HOLD;
        if (hazard())                   return BUBL;
        return NONE;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            halted_m[k] = 0; waiting_m[k] = 0; pend_m[k] = 0;
            stall_m[k] = 0; flush_m[k] = 0; cyc_m[k] = 0;
        end
    endtask

    task automatic model_step(int k);
        logic [6:0] o;
        o = predict(k);
        if (clr_stats) begin
            stall_m[k] = 0; flush_m[k] = 0; cyc_m[k] = 0;
        end else begin
            if (o[6] && !halted_m[k] && stall_m[k] < max_of(k)) stall_m[k]++;
            if (o[4] && flush_m[k] < max_of(k)) flush_m[k]++;
            if (!halted_m[k]) cyc_m[k]++;
        end
        if (halted_m[k]) begin
            if (resume) halted_m[k] = 0;
        end else if (pend_m[k] > 0) begin
            if (!mem_busy) pend_m[k]--;
        end else if (!(waiting_m[k] && mem_busy)) begin
            waiting_m[k] = 0;
            if (syscall_halt_ex)      halted_m[k] = 1;
            else if (branch_taken_ex) ;
            else if (mem_busy)        waiting_m[k] = 1;
            else if (hazard())        pend_m[k] = lu_of(k) - 1;
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) model_reset();
        else begin
            model_step(0);
            model_step(1);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        logic [6:0] e0, e1;
        e0 = rst ? predict(0) : NONE;
        e1 = rst ? predict(1) : NONE;
        chk("ctl_lu1", o1, e0);
        chk("ctl_lu3", o3, e1);
        chk("stall_lu1", stall1, stall_m[0]);
        chk("stall_lu3", stall3, stall_m[1]);
        chk("flush_lu1", flush1, flush_m[0]);
        chk("flush_lu3", flush3, flush_m[1]);
        chk("cycle_lu1", cyc1, cyc_m[0][31:0]);
        chk("cycle_lu3", cyc3, cyc_m[1][31:0]);
        if (rst && pend_m[1] > 0) chk("no_branch_in_lu_stall", branch_taken_ex, 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic clear_in();
        rs_id = 0; rt_id = 0; ex_rw = 0; rs_used_id = 0; rt_used_id = 0;
        ex_memtoreg = 0; ex_regwrite = 0; branch_taken_ex = 0;
        syscall_halt_ex = 0; mem_busy = 0; resume = 0; clr_stats = 0;
    endtask

    task automatic set_lu5();
        ex_memtoreg = 1; ex_regwrite = 1; ex_rw = 5; rs_id = 5; rs_used_id = 1;
    endtask

    longint cyc_hold;

    initial begin
        clear_in();
        repeat (3) @(posedge clk);
        #1 rst = 1;
        smp();
        chk("rst_ctl", o1, NONE);
        chk("rst_stall", stall1, 0);
        chk("rst_cycle", cyc1, 0);

        // Load-use: one bubble on LU=1, three on LU=3.
        tick(); set_lu5();
        smp(); chk("lu_b1_lu1", o1, BUBL); chk("lu_b1_lu3", o3, BUBL);
        tick(); clear_in();
        smp(); chk("lu_done_lu1", o1, NONE); chk("lu_b2_lu3", o3, BUBL); chk("lu_stall1", stall1, 1);
        tick();
        smp(); chk("lu_b3_lu3", o3, BUBL);
        tick();
        smp(); chk("lu_done_lu3", o3, NONE); chk("lu_stall3", stall3, 3);

        // No hazard on r0 destination, nor on an unused rt match.
        tick(); ex_memtoreg = 1; ex_regwrite = 1; ex_rw = 0; rs_id = 0; rs_used_id = 1;
        smp(); chk("r0_nostall", o1, NONE); chk("r0_nostall3", o3, NONE);
        tick(); ex_rw = 7; rt_id = 7; rt_used_id = 0; rs_id = 3;
        smp(); chk("rt_unused_nostall", o1, NONE);

        // Taken branch together with load-use: flush only.
        tick(); clear_in(); set_lu5(); branch_taken_ex = 1;
        smp(); chk("br_lu_ctl", o1, FLSH); chk("br_lu_ctl3", o3, FLSH);
        tick(); clear_in();
        smp(); chk("br_flush1", flush1, 1); chk("br_stall1", stall1, 1); chk("br_flush3", flush3, 1);

        // Memory wait arriving on the second bubble of a 3-bubble stall:
        // 1 bubble + 4 held cycles + 2 remaining bubbles = 7 stall cycles.
        tick(); set_lu5();
        smp(); chk("lum_b1", o3, BUBL);
        tick(); clear_in(); mem_busy = 1;
        for (int i = 0; i < 4; i++) begin
            smp(); chk("lum_hold", o3, HOLD);
            tick();
        end
        mem_busy = 0;
        smp(); chk("lum_b2", o3, BUBL);
        tick();
        smp(); chk("lum_b3", o3, BUBL);
        tick();
        smp(); chk("lum_done", o3, NONE); chk("lum_stall3", stall3, 10); chk("lum_stall1", stall1, 6);

        // Syscall halt, 10 idle cycles, resume.
        tick(); syscall_halt_ex = 1;
        smp(); chk("sys_ctl", o1, HOLD);
        tick(); syscall_halt_ex = 0; cyc_hold = cyc_m[0];
        for (int i = 0; i < 10; i++) begin
            smp(); chk("halt_ctl1", o1, HLTED); chk("halt_ctl3", o3, HLTED);
            tick();
        end
        smp(); chk("halt_cycle_frozen", cyc1, cyc_hold[31:0]);
        tick(); resume = 1;
        smp(); chk("resume_cycle_halted", o1, HLTED);
        tick(); resume = 0;
        smp(); chk("resumed", o1, NONE); chk("resumed3", o3, NONE);

        // Reset in the middle of HALT.
        tick(); syscall_halt_ex = 1;
        tick(); syscall_halt_ex = 0;
        smp(); chk("halt_again", o1, HLTED);
        #2 rst = 0;
        #1 chk("rst_mid_halt1", o1, NONE); chk("rst_mid_halt3", o3, NONE); chk("rst_mid_stall", stall1, 0);
        tick(); rst = 1;
        smp(); chk("post_rst", o1, NONE); chk("post_rst_cyc", cyc1, 0);

        // Counter saturation on the 6-bit instance, then clear during a stall.
        tick(); mem_busy = 1;
        repeat (70) tick();
        smp(); chk("sat_stall3", stall3, 63); chk("nosat_stall1", stall1, 70);
        tick(); clr_stats = 1;
        smp(); chk("clr_ctl", o1, HOLD);
        tick(); clear_in();
        smp(); chk("clr_stall1", stall1, 0); chk("clr_stall3", stall3, 0); chk("clr_cycle1", cyc1, 0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            tick();
            rs_id = 5'($urandom_range(0, 3));
            rt_id = 5'($urandom_range(0, 3));
            ex_rw = 5'($urandom_range(0, 3));
            rs_used_id  = 1'($urandom % 2);
            rt_used_id  = 1'($urandom % 2);
            ex_memtoreg = 1'($urandom % 2);
            ex_regwrite = ($urandom % 4) != 0;
            branch_taken_ex = (pend_m[1] == 0) && ($urandom % 6 == 0);
            syscall_halt_ex = ($urandom % 50 == 0);
            mem_busy  = ($urandom % 5 == 0);
            resume    = (halted_m[0] || halted_m[1]) ? ($urandom % 6 == 0) : ($urandom % 10 == 0);
            clr_stats = ($urandom % 500 == 0);
        end
        tick(); clear_in();
        smp();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
